// File: rtl/rat_io_pkg.sv
// Shared MCU I/O definitions for the framebuffer read-back engine:
// port IDs, engine state encoding and STATUS register bit positions.
package rat_io_pkg;

  localparam logic [7:0] PORT_FB_Y      = 8'h94;
  localparam logic [7:0] PORT_FB_X      = 8'h95;
  localparam logic [7:0] PORT_FB_COUNT  = 8'h96;
  localparam logic [7:0] PORT_FB_DATA   = 8'h97;
  localparam logic [7:0] PORT_FB_STATUS = 8'h98;

  localparam int STAT_BUSY  = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } fb_state_t;

  function automatic logic [7:0] fb_status(input logic busy, input logic full,
                                           input logic empty, input logic [3:0] level);
    logic [7:0] s;
    s = {4'b0000, level};
    s[STAT_BUSY]  = busy;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO: head is the oldest entry, readable
// combinationally; push and pop in the same cycle keep the level steady.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic             push_ok, pop_ok;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign head    = mem_reg[rd_ptr_reg];
  // A push into a full FIFO is accepted only when a pop frees the slot that cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fb_reader.sv
// Framebuffer read-back engine: the MCU sets a start pixel and a count, the
// engine streams pixels into a FIFO that the MCU drains through an input port.
module fb_reader
  import rat_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FB_AW      = 13
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  input  logic             RD_STRB,
  output logic [7:0]       IN_PORT,
  output logic [FB_AW-1:0] FB_RA,
  input  logic [7:0]       FB_RD,
  output logic             INTR
);

  localparam int XW = 7;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  fb_state_t        state_reg, state_next;
  logic [FB_AW-1:0] addr_reg, addr_next;
  logic [FB_AW-1:0] ra_hold_reg, ra_hold_next;
  logic [8:0]       count_reg, count_next;
  logic             pop, fifo_push, fifo_full, fifo_empty, last_capture;
  logic [LW-1:0]    fifo_level;
  logic [7:0]       fifo_head;

  assign pop          = RD_STRB && (PORT_ID == PORT_FB_DATA);
  assign last_capture = (state_reg == ST_CAPTURE) && (count_reg == 9'd1);
  assign INTR         = last_capture;
  // The read address is only live while issuing; otherwise the last one is held.
  assign FB_RA        = (state_reg == ST_ISSUE) ? addr_reg : ra_hold_reg;

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    count_next   = count_reg;
    ra_hold_next = ra_hold_reg;
    fifo_push    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (IO_STRB) begin
          case (PORT_ID)
            PORT_FB_Y:     addr_next = {OUT_PORT[FB_AW-XW-1:0], addr_reg[XW-1:0]};
            PORT_FB_X:     addr_next = {addr_reg[FB_AW-1:XW], OUT_PORT[XW-1:0]};
            PORT_FB_COUNT: begin
              count_next = (OUT_PORT == 8'h00) ? 9'd256 : {1'b0, OUT_PORT};
              state_next = ST_ISSUE;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        ra_hold_next = addr_reg;
        if (!fifo_full || pop) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        fifo_push  = 1'b1;
        addr_next  = addr_reg + FB_AW'(1);
        count_next = count_reg - 9'd1;
        state_next = (count_reg == 9'd1) ? ST_IDLE : ST_ISSUE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      count_reg   <= '0;
      ra_hold_reg <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      count_reg   <= count_next;
      ra_hold_reg <= ra_hold_next;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .push      (fifo_push),
    .push_data (FB_RD),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (fifo_head)
  );

  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      PORT_FB_DATA:   IN_PORT = fifo_empty ? 8'h00 : fifo_head;
      PORT_FB_STATUS: IN_PORT = fb_status(state_reg != ST_IDLE, fifo_full, fifo_empty,
                                          4'(fifo_level));
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader: a RAM model returns a[7:0], expected pixels and
// addresses go into scoreboard queues when a burst is started.
module tb_fb_reader;

  logic        CLK, RESET_N;
  logic [7:0]  PORT_ID, OUT_PORT, IN_PORT, FB_RD;
  logic        IO_STRB, RD_STRB, INTR;
  logic [12:0] FB_RA;

  int n_checks = 0;
  int n_fail   = 0;
  int intr_cnt = 0;
  int exp_intr = 0;

  logic [7:0]  exp_q[$];
  logic [12:0] exp_addr_q[$];
  logic [12:0] obs_addr_q[$];
  logic [12:0] last_ra = 13'h0;

  fb_reader #(.FIFO_DEPTH(8), .FB_AW(13)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .RD_STRB(RD_STRB), .IN_PORT(IN_PORT), .FB_RA(FB_RA),
    .FB_RD(FB_RD), .INTR(INTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) FB_RD <= FB_RA[7:0];

  always @(negedge CLK) begin
    if (INTR) intr_cnt++;
    if (FB_RA != last_ra) begin
      obs_addr_q.push_back(FB_RA);
      last_ra = FB_RA;
    end
  end

  task automatic check_val(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] d);
    @(negedge CLK);
    PORT_ID = id; OUT_PORT = d; IO_STRB = 1'b1;
    @(negedge CLK);
    IO_STRB = 1'b0;
  endtask

  task automatic start_burst(input logic [5:0] y, input logic [6:0] x, input logic [7:0] cnt);
    logic [12:0] a;
    int n;
    a = {y, x};
    n = (cnt == 8'h00) ? 256 : int'(cnt);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a[7:0]);
      exp_addr_q.push_back(a);
      a = a + 13'd1;
    end
    exp_intr++;
    io_write(8'h94, {2'b00, y});
    io_write(8'h95, {1'b0, x});
    io_write(8'h96, cnt);
    $display("burst y=0x%0h x=0x%0h count=0x%0h", y, x, cnt);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] d, e;
    @(negedge CLK);
    PORT_ID = 8'h97; RD_STRB = 1'b1;
    #1 d = IN_PORT;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check_val(tag, 16'(d), 16'(e));
    $display("pop %s data=0x%02h", tag, d);
    @(negedge CLK);
    RD_STRB = 1'b0;
  endtask

  task automatic status_check(input string tag, input logic [7:0] e);
    @(negedge CLK);
    PORT_ID = 8'h98;
    #1 check_val(tag, 16'(IN_PORT), 16'(e));
    $display("status %s value=0x%02h", tag, IN_PORT);
  endtask

  task automatic wait_intr(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (INTR) seen = 1'b1;
      else @(negedge CLK);
    end
    check_val(tag, 16'(seen), 16'(1));
    @(negedge CLK);
  endtask

  task automatic check_addrs(input string tag);
    check_val({tag, "_n"}, 16'(obs_addr_q.size()), 16'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size(); i++)
      check_val(tag, (i < obs_addr_q.size()) ? 16'(obs_addr_q[i]) : 16'hFFFF,
                16'(exp_addr_q[i]));
    exp_addr_q.delete();
    obs_addr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, st;
    logic found;
    RESET_N = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0; RD_STRB = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    obs_addr_q.delete();

    // Reset state
    status_check("rst_status", 8'h20);
    check_val("rst_fb_ra", 16'(FB_RA), 16'h0000);
    check_val("rst_intr", 16'(INTR), 16'h0000);
    PORT_ID = 8'h97;
    #1 check_val("rst_data", 16'(IN_PORT), 16'h0000);

    // Basic 3-pixel burst crossing X into the next Y line offset
    start_burst(6'h02, 7'h7E, 8'h03);
    wait_intr("b1_intr", 40);
    status_check("b1_status", 8'h03);
    for (int i = 0; i < 3; i++) pop_check("b1_pop");
    check_val("b1_intr_cnt", 16'(intr_cnt), 16'(exp_intr));
    check_addrs("b1_addr");

    // Backpressure: FIFO fills, engine stalls, two pops finish the burst
    start_burst(6'h00, 7'h10, 8'h0A);
    repeat (30) @(negedge CLK);
    status_check("b2_stall", 8'hC8);
    check_val("b2_no_intr", 16'(intr_cnt), 16'(exp_intr - 1));
    pop_check("b2_pop");
    pop_check("b2_pop");
    wait_intr("b2_intr", 20);
    status_check("b2_full_idle", 8'h48);
    for (int i = 0; i < 8; i++) pop_check("b2_pop");
    status_check("b2_drained", 8'h20);
    check_addrs("b2_addr");

    // Address wrap at the top of the framebuffer
    start_burst(6'h3F, 7'h7F, 8'h02);
    wait_intr("b3_intr", 40);
    for (int i = 0; i < 2; i++) pop_check("b3_pop");
    check_addrs("b3_addr");

    // Writes while busy are ignored
    start_burst(6'h01, 7'h00, 8'h04);
    io_write(8'h96, 8'h05);
    io_write(8'h95, 8'h10);
    wait_intr("b4_intr", 40);
    status_check("b4_level", 8'h04);
    for (int i = 0; i < 4; i++) pop_check("b4_pop");
    status_check("b4_empty", 8'h20);
    check_addrs("b4_addr");
    check_val("b4_intr_cnt", 16'(intr_cnt), 16'(exp_intr));

    // Pop while empty, then push+pop in the same cycle at level 3
    pop_check("empty_pop");
    status_check("empty_status", 8'h20);
    start_burst(6'h00, 7'h40, 8'h04);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      PORT_ID = 8'h98;
      #1 if (INTR) found = 1'b1;
    end
    check_val("pp_found", 16'(found), 16'(1));
    st = IN_PORT;
    check_val("pp_pre_status", 16'(st), 16'h0083);
    PORT_ID = 8'h97; RD_STRB = 1'b1;
    #1 d = IN_PORT;
    check_val("pp_pop", 16'(d), 16'((exp_q.size() > 0) ? exp_q.pop_front() : 8'h00));
    @(negedge CLK);
    RD_STRB = 1'b0; PORT_ID = 8'h98;
    #1 check_val("pp_post_status", 16'(IN_PORT), 16'h0003);
    for (int i = 0; i < 3; i++) pop_check("pp_pop");
    check_addrs("pp_addr");

    // Reset mid-burst at level 4
    start_burst(6'h00, 7'h20, 8'h0A);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      PORT_ID = 8'h98;
      #1 if (IN_PORT == 8'h84) found = 1'b1;
    end
    check_val("mr_found", 16'(found), 16'(1));
    RESET_N = 1'b0;
    exp_intr--;
    #1;
    check_val("mr_status", 16'(IN_PORT), 16'h0020);
    check_val("mr_fb_ra", 16'(FB_RA), 16'h0000);
    check_val("mr_intr", 16'(INTR), 16'h0000);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    obs_addr_q.delete();
    repeat (20) @(negedge CLK);
    check_val("mr_intr_cnt", 16'(intr_cnt), 16'(exp_intr));
    status_check("mr_post_status", 8'h20);

    // Operation resumes after reset
    start_burst(6'h00, 7'h05, 8'h01);
    wait_intr("rs_intr", 20);
    pop_check("rs_pop");
    check_addrs("rs_addr");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the read-back FIFO depth in pixels (power of two, 2..16).
REQ-002 The block SHALL have parameter FB_AW, default 13, meaning the framebuffer address width as {Y[5:0],X[6:0]}.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port PORT_ID  input  8  MCU port identifier.
REQ-006 The block SHALL have port OUT_PORT  input  8  MCU output data.
REQ-007 The block SHALL have port IO_STRB  input  1  MCU output-write strobe, one cycle per OUT.
REQ-008 The block SHALL have port RD_STRB  input  1  MCU input-read strobe, one cycle per IN.
REQ-009 The block SHALL have port IN_PORT  output  8  read data returned to the MCU.
REQ-010 The block SHALL have port FB_RA  output  FB_AW  framebuffer read address.
REQ-011 The block SHALL have port FB_RD  input  8  framebuffer read data, valid exactly one cycle after FB_RA.
REQ-012 The block SHALL have port INTR  output  1  burst-complete pulse.

Function
REQ-013 Port map SHALL be: 0x94 write Y (bits 5:0), 0x95 write X (bits 6:0), 0x96 write COUNT and start burst, 0x97 read DATA (pops FIFO), 0x98 read STATUS.
REQ-014 A write is any cycle with IO_STRB=1; a DATA pop is any cycle with RD_STRB=1 and PORT_ID=0x97.
REQ-015 IN_PORT SHALL be combinational: 0x97 -> FIFO head (0x00 when empty); 0x98 -> {busy, full, empty, 1'b0, level[3:0]}; any other ID -> 0x00.
REQ-016 Engine FSM states SHALL be IDLE, ISSUE, CAPTURE.
REQ-017 IDLE->ISSUE on a COUNT write; remaining count := OUT_PORT, where 0x00 means 256 pixels.
REQ-018 ISSUE: FB_RA drives the current address; go to CAPTURE only if the FIFO is not full, or a pop occurs in the same cycle; otherwise stay in ISSUE.
REQ-019 CAPTURE: push FB_RD into the FIFO, increment the address, and decrement the remaining count; go to ISSUE if count remains, else to IDLE with INTR=1 for exactly that cycle.
REQ-020 Throughput SHALL be one pixel per two cycles when the FIFO is not full.
REQ-021 The address SHALL increment linearly modulo 2^FB_AW: X 127->0 carries into Y, and 0x1FFF wraps to 0x0000.
REQ-022 Writes to 0x94, 0x95 or 0x96 while busy (state != IDLE) SHALL be ignored.
REQ-023 A pop while empty SHALL return 0x00 and change no state.
REQ-024 A simultaneous push and pop SHALL leave the level unchanged and preserve FIFO order.
REQ-025 busy SHALL equal (state != IDLE); the FIFO is not flushed at burst end; leftover data remains poppable.
REQ-026 FB_RA SHALL hold the last address driven while in IDLE.

Reset
REQ-027 On RESET_N=0 the block SHALL asynchronously go to: state IDLE, address 0, count 0, FIFO level 0, INTR 0, FB_RA 0.
REQ-028 A reset mid-burst SHALL abort the burst, discard FIFO contents, and generate no INTR.
REQ-029 Operation SHALL resume on the first rising CLK edge after RESET_N returns high.

Structure
REQ-030 Port IDs 0x94-0x98, the FSM state enum and the status-bit positions SHALL live in the shared package rat_io_pkg.
REQ-031 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH=8 and DEPTH), with push, pop, full, empty, level and head outputs.

Verification
REQ-032 Write Y=0x02, X=0x7E, COUNT=0x03, with RAM[a]=a[7:0] -> FB_RA sequence 0x017E, 0x017F, 0x0180; pops return 0x7E, 0x7F, 0x80; INTR pulses once.
REQ-033 Start COUNT=0x0A with no pops -> engine stalls in ISSUE with STATUS=0xC8; popping 2 pixels completes the burst; 10 pixels total are delivered in order.
REQ-034 Start at Y=0x3F, X=0x7F, COUNT=0x02 -> addresses 0x1FFF, 0x0000.
REQ-035 Write COUNT=0x05 and X=0x10 while busy -> ignored; burst length remains the original value and the address is unchanged.
REQ-036 Pop when empty -> IN_PORT=0x00, STATUS=0x20; a simultaneous push and pop at level 3 -> level stays 3.
REQ-037 Assert RESET_N low mid-burst at level 4 -> STATUS=0x20 immediately, INTR never pulses, and FB_RA=0.
